// File: rtl/alu_sequencer_pkg.sv
// ============================================================================
// Module      : alu_sequencer_pkg
// Description : Shared func codes, instruction field positions and FSM states
//               for the ALU issue sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package alu_sequencer_pkg;

    localparam int c_data_w   = 16;
    localparam int c_rf_depth = 8;

    localparam int c_func_msb = 15;
    localparam int c_func_lsb = 12;
    localparam int c_rd_msb   = 11;
    localparam int c_rd_lsb   = 9;
    localparam int c_ra_msb   = 8;
    localparam int c_ra_lsb   = 6;
    localparam int c_rb_msb   = 5;
    localparam int c_rb_lsb   = 3;

    typedef enum logic [3:0] {
        FUNC_MOV_B = 4'b0000,
        FUNC_ADD   = 4'b0001,
        FUNC_SUB   = 4'b0010,
        FUNC_AND   = 4'b0011,
        FUNC_OR    = 4'b0100,
        FUNC_SHL   = 4'b0101,
        FUNC_SHR   = 4'b0110,
        FUNC_CMP   = 4'b1011,
        FUNC_STR   = 4'b1100,
        FUNC_LDR   = 4'b1101,
        FUNC_XOR   = 4'b1110,
        FUNC_XNOR  = 4'b1111
    } func_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_WB    = 2'd3
    } state_t;

    // Codes the ALU does not implement are rejected before issue.
    function automatic logic is_illegal_func(input logic [3:0] func);
        return (func == 4'b0111) || (func == 4'b1000) ||
               (func == 4'b1001) || (func == 4'b1010);
    endfunction

endpackage

`default_nettype wire

// File: rtl/alu_sequencer_regfile.sv
// ============================================================================
// Module      : seq_regfile
// Description : 8x16 register file, two operand read ports plus a debug port,
//               write-back port taking priority over the external port.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module seq_regfile
    import alu_sequencer_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                wb_we,
    input  logic [2:0]          wb_addr,
    input  logic [c_data_w-1:0] wb_data,
    input  logic                ext_we,
    input  logic [2:0]          ext_addr,
    input  logic [c_data_w-1:0] ext_data,
    input  logic [2:0]          raddr_a,
    output logic [c_data_w-1:0] rdata_a,
    input  logic [2:0]          raddr_b,
    output logic [c_data_w-1:0] rdata_b,
    input  logic [2:0]          dbg_addr,
    output logic [c_data_w-1:0] dbg_data
);

    logic [c_data_w-1:0] r_mem [c_rf_depth];

    // The later assignment wins, so a same-address collision keeps the WB data.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < c_rf_depth; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (ext_we) begin
                r_mem[ext_addr] <= ext_data;
            end
            if (wb_we) begin
                r_mem[wb_addr] <= wb_data;
            end
        end
    end

    assign rdata_a  = r_mem[raddr_a];
    assign rdata_b  = r_mem[raddr_b];
    assign dbg_data = r_mem[dbg_addr];

endmodule

`default_nettype wire

// File: rtl/alu_sequencer.sv
// ============================================================================
// Module      : alu_sequencer
// Description : Single-issue controller feeding the 16-bit ALU; reads operands,
//               waits for the registered result and writes it back.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_sequencer
    import alu_sequencer_pkg::*;
#(
    parameter int TIMEOUT = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        instr_valid,
    input  logic [15:0] instr,
    output logic        instr_ready,
    output logic        alu_en,
    output logic [3:0]  alu_func,
    output logic [15:0] alu_a,
    output logic [15:0] alu_b,
    input  logic        alu_done,
    input  logic [15:0] alu_result,
    input  logic        rf_we,
    input  logic [2:0]  rf_waddr,
    input  logic [15:0] rf_wdata,
    input  logic [2:0]  dbg_addr,
    output logic [15:0] dbg_data,
    output logic [2:0]  flags,
    output logic        done,
    output logic        err
);

    localparam logic [3:0] c_cnt_last = 4'(TIMEOUT - 1);

    state_t      r_state;
    state_t      w_next_state;
    logic        w_accept;
    logic        w_err_set;
    logic [3:0]  r_func;
    logic [2:0]  r_rd;
    logic [2:0]  r_ra;
    logic [2:0]  r_rb;
    logic [3:0]  r_cnt;
    logic [15:0] r_result;
    logic [2:0]  r_flags;
    logic        r_err;
    logic [15:0] r_alu_a;
    logic [15:0] r_alu_b;
    logic [15:0] w_rdata_a;
    logic [15:0] w_rdata_b;
    logic        w_wb_we;
    logic [3:0]  w_instr_func;
    logic        w_unused_bits;

    assign w_instr_func  = instr[c_func_msb:c_func_lsb];
    assign w_unused_bits = ^instr[2:0];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_accept     = 1'b0;
        w_err_set    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (instr_valid && instr_ready) begin
                    if (is_illegal_func(w_instr_func)) begin
                        w_err_set = 1'b1;
                    end else begin
                        w_accept     = 1'b1;
                        w_next_state = ST_ISSUE;
                    end
                end
            end
            ST_ISSUE: w_next_state = ST_WAIT;
            ST_WAIT: begin
                if (alu_done) begin
                    w_next_state = ST_WB;
                end else if (r_cnt == c_cnt_last) begin
                    w_err_set    = 1'b1;
                    w_next_state = ST_IDLE;
                end
            end
            ST_WB:   w_next_state = ST_IDLE;
            default: w_next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_func   <= '0;
            r_rd     <= '0;
            r_ra     <= '0;
            r_rb     <= '0;
            r_cnt    <= '0;
            r_result <= '0;
            r_flags  <= '0;
            r_err    <= 1'b0;
            r_alu_a  <= '0;
            r_alu_b  <= '0;
        end else begin
            r_err <= w_err_set;
            if (w_accept) begin
                r_func <= w_instr_func;
                r_rd   <= instr[c_rd_msb:c_rd_lsb];
                r_ra   <= instr[c_ra_msb:c_ra_lsb];
                r_rb   <= instr[c_rb_msb:c_rb_lsb];
            end
            if (r_state == ST_ISSUE) begin
                r_alu_a <= w_rdata_a;
                r_alu_b <= w_rdata_b;
            end
            r_cnt <= (r_state == ST_WAIT) ? r_cnt + 4'd1 : 4'd0;
            if (r_state == ST_WAIT && alu_done) begin
                r_result <= alu_result;
            end
            if (r_state == ST_WB && r_func == FUNC_CMP) begin
                r_flags <= r_result[2:0];
            end
        end
    end

    assign w_wb_we = (r_state == ST_WB) && (r_func != FUNC_CMP);

    seq_regfile u_regfile (
        .clk      (clk),
        .rst      (rst),
        .wb_we    (w_wb_we),
        .wb_addr  (r_rd),
        .wb_data  (r_result),
        .ext_we   (rf_we),
        .ext_addr (rf_waddr),
        .ext_data (rf_wdata),
        .raddr_a  (r_ra),
        .rdata_a  (w_rdata_a),
        .raddr_b  (r_rb),
        .rdata_b  (w_rdata_b),
        .dbg_addr (dbg_addr),
        .dbg_data (dbg_data)
    );

    // Ready is gated by the reset pin so it reads 0 while reset is held.
    assign instr_ready = rst && (r_state == ST_IDLE);
    assign alu_en      = (r_state == ST_ISSUE);
    assign alu_func    = r_func;
    assign alu_a       = alu_en ? w_rdata_a : r_alu_a;
    assign alu_b       = alu_en ? w_rdata_b : r_alu_b;
    assign flags       = r_flags;
    assign done        = (r_state == ST_WB);
    assign err         = r_err;

endmodule

`default_nettype wire

// File: tb/tb_alu_sequencer.sv
// ============================================================================
// Module      : tb_alu_sequencer
// Description : Self-checking bench for alu_sequencer with an ALU stub and a
//               transaction-level model of registers, flags and output timing.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_alu_sequencer;
    import alu_sequencer_pkg::*;

    localparam int TIMEOUT = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        instr_valid = 1'b0;
    logic [15:0] instr = '0;
    logic        instr_ready;
    logic        alu_en;
    logic [3:0]  alu_func;
    logic [15:0] alu_a;
    logic [15:0] alu_b;
    logic        alu_done = 1'b0;
    logic [15:0] alu_result = '0;
    logic        rf_we = 1'b0;
    logic [2:0]  rf_waddr = '0;
    logic [15:0] rf_wdata = '0;
    logic [2:0]  dbg_addr = '0;
    logic [15:0] dbg_data;
    logic [2:0]  flags;
    logic        done;
    logic        err;

    alu_sequencer #(.TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst), .instr_valid(instr_valid), .instr(instr),
        .instr_ready(instr_ready), .alu_en(alu_en), .alu_func(alu_func),
        .alu_a(alu_a), .alu_b(alu_b), .alu_done(alu_done), .alu_result(alu_result),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .dbg_addr(dbg_addr), .dbg_data(dbg_data), .flags(flags), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Expected state of the design, advanced one transaction step at a time.
    logic [15:0] exp_rf [8];
    logic [2:0]  exp_flags = '0;
    logic        exp_ready = 1'b0;
    logic        exp_en = 1'b0;
    logic        exp_done = 1'b0;
    logic        exp_err = 1'b0;
    logic [3:0]  exp_func = '0;
    logic [15:0] exp_a = '0;
    logic [15:0] exp_b = '0;
    bit          chk_on = 1'b0;
    bit          ext_rand = 1'b0;

    function automatic logic [15:0] alu_ref(input logic [3:0] f, input logic [15:0] a, input logic [15:0] b);
        case (f)
            4'd0:    return b;
            4'd1:    return a + b;
            4'd2:    return a - b;
            4'd3:    return a & b;
            4'd4:    return a | b;
            4'd5:    return a << b[3:0];
            4'd6:    return a >> b[3:0];
            4'd11:   return {13'd0, a < b, a > b, a == b};
            4'd12:   return a;
            4'd13:   return b;
            4'd14:   return a ^ b;
            4'd15:   return ~(a ^ b);
            default: return 16'h0;
        endcase
    endfunction

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got 0x%h, expected 0x%h at %0t", name, act, expv, $time);
        end
    endtask

    // ALU stub: result appears stub_lat cycles after alu_en; 0 means never.
    int          stub_lat = 1;
    int          stub_cnt = 0;
    bit          stub_noise = 1'b0;
    logic [15:0] stub_res = '0;

    always @(negedge clk) begin
        if (alu_en === 1'b1 && stub_lat > 0) begin
            stub_res = alu_ref(alu_func, alu_a, alu_b);
            stub_cnt = stub_lat;
        end
    end

    always @(posedge clk) begin
        #1;
        if (stub_cnt > 0) begin
            stub_cnt--;
            alu_done   = (stub_cnt == 0);
            alu_result = (stub_cnt == 0) ? stub_res : 16'($urandom);
        end else begin
            alu_done   = stub_noise && ($urandom_range(0, 2) == 0);
            alu_result = 16'($urandom);
        end
    end

    always @(negedge clk) begin
        if (chk_on) begin
            check("instr_ready", 16'(instr_ready), 16'(exp_ready));
            check("alu_en",      16'(alu_en),      16'(exp_en));
            check("done",        16'(done),        16'(exp_done));
            check("err",         16'(err),         16'(exp_err));
            check("alu_func",    16'(alu_func),    16'(exp_func));
            check("alu_a",       alu_a,            exp_a);
            check("alu_b",       alu_b,            exp_b);
            check("flags",       16'(flags),       16'(exp_flags));
            check("dbg_data",    dbg_data,         exp_rf[dbg_addr]);
        end
    end

    // Advance one cycle; apply the writes the edge performed to the model.
    task automatic tick(input bit wb, input logic [2:0] wb_addr, input logic [15:0] wb_data);
        @(posedge clk);
        #1;
        if (rf_we && rst) exp_rf[rf_waddr] = rf_wdata;
        if (wb) exp_rf[wb_addr] = wb_data;
        rf_we = 1'b0;
        if (ext_rand && $urandom_range(0, 3) == 0) begin
            rf_we    = 1'b1;
            rf_waddr = 3'($urandom);
            rf_wdata = 16'($urandom);
        end
        dbg_addr    = 3'($urandom);
        instr_valid = 1'b0;
        instr       = 16'($urandom);
        exp_done    = 1'b0;
        exp_err     = 1'b0;
        exp_en      = 1'b0;
    endtask

    task automatic junk_valid();
        instr_valid = 1'($urandom);
        instr       = 16'($urandom);
    endtask

    task automatic ext_write(input logic [2:0] a, input logic [15:0] d);
        rf_we = 1'b1; rf_waddr = a; rf_wdata = d;
        tick(1'b0, 3'd0, 16'd0);
    endtask

    task automatic peek(input string name, input logic [2:0] a, input logic [15:0] lit);
        dbg_addr = a;
        #1;
        check(name, dbg_data, lit);
    endtask

    // One instruction from the current (idle) cycle to the first idle cycle after it.
    task automatic do_instr(input logic [3:0] f, input logic [2:0] rd, input logic [2:0] ra,
                            input logic [2:0] rb, input int lat, input bit collide, input bit noise);
        logic [15:0] res;
        int          waits;
        stub_lat    = lat;
        stub_noise  = noise && (lat != 0);
        instr_valid = 1'b1;
        instr       = {f, rd, ra, rb, 3'($urandom)};
        exp_ready   = 1'b1;
        tick(1'b0, 3'd0, 16'd0);
        if (f == 4'b0111 || f == 4'b1000 || f == 4'b1001 || f == 4'b1010) begin
            exp_err = 1'b1;
            return;
        end
        exp_ready = 1'b0;
        exp_en    = 1'b1;
        exp_func  = f;
        exp_a     = exp_rf[ra];
        exp_b     = exp_rf[rb];
        res       = alu_ref(f, exp_a, exp_b);
        junk_valid();
        tick(1'b0, 3'd0, 16'd0);
        waits = (lat == 0) ? TIMEOUT : lat;
        for (int k = 0; k < waits; k++) begin
            junk_valid();
            tick(1'b0, 3'd0, 16'd0);
        end
        if (lat == 0) begin
            exp_ready = 1'b1;
            exp_err   = 1'b1;
            return;
        end
        exp_done = 1'b1;
        junk_valid();
        if (collide) begin
            rf_we = 1'b1; rf_waddr = rd; rf_wdata = 16'($urandom);
        end
        tick(f != 4'd11, rd, res);
        if (f == 4'd11) exp_flags = res[2:0];
        exp_ready = 1'b1;
    endtask

    initial begin
        for (int i = 0; i < 8; i++) exp_rf[i] = '0;
        #1 rst = 1'b0;
        chk_on = 1'b1;
        tick(1'b0, 3'd0, 16'd0);
        check("reset_flags", 16'(flags), 16'h0000);
        rst = 1'b1;
        exp_ready = 1'b1;
        tick(1'b0, 3'd0, 16'd0);

        ext_write(3'd1, 16'h0005);
        ext_write(3'd2, 16'h0003);
        ext_write(3'd7, 16'h0001);

        do_instr(4'd1, 3'd3, 3'd1, 3'd2, 1, 1'b0, 1'b0);
        peek("add_r3", 3'd3, 16'h0008);
        check("model_r3", exp_rf[3], 16'h0008);

        do_instr(4'd11, 3'd3, 3'd1, 3'd2, 1, 1'b0, 1'b0);
        check("cmp_gt", 16'(flags), 16'h0002);
        peek("cmp_rd_kept", 3'd3, 16'h0008);
        do_instr(4'd11, 3'd0, 3'd1, 3'd1, 1, 1'b0, 1'b0);
        check("cmp_eq", 16'(flags), 16'h0001);

        do_instr(4'd2, 3'd4, 3'd1, 3'd2, 1, 1'b0, 1'b0);
        do_instr(4'd5, 3'd5, 3'd4, 3'd7, 1, 1'b0, 1'b0);
        peek("sub_r4", 3'd4, 16'h0002);
        peek("shl_r5", 3'd5, 16'h0004);

        do_instr(4'b0111, 3'd3, 3'd1, 3'd2, 1, 1'b0, 1'b0);
        peek("illegal_r3", 3'd3, 16'h0008);
        tick(1'b0, 3'd0, 16'd0);

        do_instr(4'd1, 3'd6, 3'd1, 3'd2, 0, 1'b0, 1'b0);
        peek("timeout_r6", 3'd6, 16'h0000);
        do_instr(4'd4, 3'd6, 3'd1, 3'd2, 1, 1'b0, 1'b0);
        peek("or_r6", 3'd6, 16'h0007);
        do_instr(4'd14, 3'd0, 3'd1, 3'd2, TIMEOUT, 1'b0, 1'b0);
        peek("xor_late_r0", 3'd0, 16'h0006);

        // Reset in the middle of a WAIT that would never finish.
        stub_lat = 0;
        instr_valid = 1'b1;
        instr = {4'd1, 3'd6, 3'd1, 3'd2, 3'd0};
        tick(1'b0, 3'd0, 16'd0);
        exp_ready = 1'b0; exp_en = 1'b1; exp_func = 4'd1;
        exp_a = exp_rf[1]; exp_b = exp_rf[2];
        tick(1'b0, 3'd0, 16'd0);
        tick(1'b0, 3'd0, 16'd0);
        rst = 1'b0;
        for (int i = 0; i < 8; i++) exp_rf[i] = '0;
        exp_flags = '0; exp_func = '0; exp_a = '0; exp_b = '0;
        tick(1'b0, 3'd0, 16'd0);
        peek("rst_r1", 3'd1, 16'h0000);
        rst = 1'b1;
        exp_ready = 1'b1;
        tick(1'b0, 3'd0, 16'd0);

        ext_write(3'd1, 16'h0005);
        ext_write(3'd2, 16'h0003);
        do_instr(4'd1, 3'd6, 3'd1, 3'd2, 1, 1'b1, 1'b0);
        peek("collide_r6", 3'd6, 16'h0008);

        ext_rand = 1'b1;
        for (int n = 0; n < 150; n++) begin
            int r;
            int gap;
            r = $urandom_range(0, 9);
            do_instr(4'($urandom), 3'($urandom), 3'($urandom), 3'($urandom),
                     (r == 0) ? 0 : 1 + (r % TIMEOUT), ($urandom_range(0, 3) == 0), 1'b1);
            gap = $urandom_range(0, 2);
            for (int g = 0; g < gap; g++) tick(1'b0, 3'd0, 16'd0);
        end
        ext_rand = 1'b0;
        stub_noise = 1'b0;
        tick(1'b0, 3'd0, 16'd0);
        tick(1'b0, 3'd0, 16'd0);
        chk_on = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/alu_sequencer.md
# alu_sequencer

Multi-cycle issue controller sitting in front of the 16-bit ALU. It accepts 16-bit register-to-register instructions over a valid/ready handshake and reads operands from an internal 8×16 register file. It drives the ALU's enable/function/operand inputs, waits for the ALU's registered result, and writes it back to the register file or to the compare-flag register. One instruction is in flight at a time.

## Interface
- TIMEOUT, 4, max cycles in WAIT for `alu_done` before aborting (1..15)
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-low
- instr_valid  in  1  instruction offered
- instr  in  16  [15:12] func, [11:9] rd, [8:6] ra, [5:3] rb, [2:0] ignored
- instr_ready  out  1  sequencer can accept
- alu_en  out  1  to ALU en_in
- alu_func  out  4  to ALU alu_func
- alu_a, alu_b  out  16 each  to ALU operands
- alu_done  in  1  from ALU en_out
- alu_result  in  16  from ALU alu_out
- rf_we  in  1  external register write strobe
- rf_waddr  in  3  external write address
- rf_wdata  in  16  external write data
- dbg_addr  in  3  debug read address
- dbg_data  out  16  combinational read of reg[dbg_addr]
- flags  out  3  {lt, gt, eq} from last CMP
- done  out  1  one-cycle pulse at write-back
- err  out  1  one-cycle pulse on illegal func or timeout

## Operation
- States: IDLE, ISSUE, WAIT, WB.
- IDLE:
  - `instr_ready=1`.
  - On `instr_valid & instr_ready`, latch `instr` and go to ISSUE.
  - If func ∈ {0111, 1000, 1001, 1010}, pulse `err` next cycle and stay in IDLE instead.
- ISSUE:
  - `alu_en=1` for exactly this cycle.
  - `alu_func` = latched func; `alu_a` = reg[ra], `alu_b` = reg[rb], both read this cycle.
  - Go to WAIT.
- WAIT:
  - `alu_en=0`; count cycles.
  - On `alu_done=1`, capture `alu_result` and go to WB.
  - If the count reaches TIMEOUT without `alu_done`, pulse `err`, discard the instruction and go to IDLE with no write.
- WB:
  - CMP (1011): `flags` ← `alu_result[2:0]` mapped as eq=bit0, gt=bit1, lt=bit2; reg[rd] is unchanged.
  - Any other func: reg[rd] ← captured result.
  - Pulse `done`, go to IDLE.
- `alu_func`, `alu_a`, `alu_b` hold their last values outside ISSUE.
- External write: `rf_we` writes reg[rf_waddr] in any state. If it hits the same register as a WB write in the same cycle, the WB write wins.
- Read-during-write: operands read in ISSUE see the pre-write value; `dbg_data` shows the pre-edge value.

## Timing
- Reset values:
  - All outputs 0; state IDLE; all registers and `flags` = 0.
  - `instr_ready` is 1 from the first cycle after reset deasserts.
- Nominal ALU (`alu_done` the cycle after `alu_en`): accept at T, ISSUE at T+1, WAIT at T+2 (done seen), WB at T+3 with `done=1`, IDLE at T+4.
- Throughput: one instruction per 4 cycles. `instr_ready` is 0 from T+1 to T+3.
- Back-to-back dependency: an instruction accepted at T+4 reads the value written at T+3.
- `alu_done` asserted outside WAIT is ignored.
- Reset asserted mid-instruction: immediate return to IDLE; register file and `flags` clear; no `done`/`err` pulse.
- Illegal-func `err` pulse occurs at T+1; `instr_ready` stays 1.

## Structure
- Shared package: func code constants (MOV_B=0000, ADD=0001, SUB=0010, AND=0011, OR=0100, SHL=0101, SHR=0110, CMP=1011, STR=1100, LDR=1101, XOR=1110, XNOR=1111), instruction field positions, state encoding.
- Sub-module `seq_regfile`: 8×16, two combinational read ports plus debug read, two prioritized write ports (WB over external), async active-low clear.

## Test plan
- Preload r1=0x0005, r2=0x0003 via `rf_we`; issue ADD rd=3, ra=1, rb=2 -> r3=0x0008, `done` at T+3, `instr_ready` low T+1..T+3.
- CMP with ra=r1, rb=r2 (5 vs 3) -> `flags`=3'b010 (gt); rd unchanged. Then CMP with ra=rb -> `flags`=3'b001.
- Back-to-back: SUB r4=r1-r2, then SHL r5=r4 -> r4=0x0002, r5=0x0004; second instruction accepted at T+4.
- Illegal func 0111 -> `err` pulse at T+1, no `alu_en`, no register change.
- ALU stub never asserts `alu_done` -> `err` after 4 WAIT cycles, returns to IDLE, rd unchanged. Then a normal instruction completes.
- Assert rst during WAIT -> all outputs 0 and registers cleared next cycle; WB collision with `rf_we` on the same rd -> WB value retained.
